// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if: serial slot stream in, reassembled frame and status out.
interface tdm_demux8_if #(parameter int W = 1);
  logic [W-1:0] din;
  logic din_valid;
  logic frame_sync;
  logic [8*W-1:0] dout;
  logic frame_valid;
  logic locked;
  logic [2:0] slot;
  logic sync_err;
  modport master (output din, din_valid, frame_sync, input dout, frame_valid, locked, slot, sync_err);
  modport slave (input din, din_valid, frame_sync, output dout, frame_valid, locked, slot, sync_err);
endinterface

// File: rtl/tdm_demux8.sv
// tdm_demux8: 1-to-8 TDM demultiplexer with HUNT/LOCKED frame alignment.
module tdm_demux8 #(
  parameter int W = 1,
  parameter bit SYNC_EVERY_FRAME = 1'b1
) (
  input logic clk,
  input logic rst,
  tdm_demux8_if.slave bus
);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state;
  logic [2:0] cnt;
  logic [7*W-1:0] shadow;
  logic [8*W-1:0] dout_r;
  logic fv, err;
  // Lane 7 never lands in the shadow; it goes straight into dout with lanes 6..0.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= HUNT;
      cnt <= '0;
      shadow <= '0;
      dout_r <= '0;
      fv <= 1'b0;
      err <= 1'b0;
    end else begin
      fv <= 1'b0;
      err <= 1'b0;
      if (bus.din_valid) begin
        if (state == HUNT) begin
          if (bus.frame_sync) begin
            shadow[0 +: W] <= bus.din;
            cnt <= 3'd1;
            state <= LOCKED;
          end
        end else if (bus.frame_sync) begin
          err <= cnt != 3'd0;
          shadow[0 +: W] <= bus.din;
          cnt <= 3'd1;
        end else if (cnt == 3'd0 && SYNC_EVERY_FRAME) begin
          err <= 1'b1;
          state <= HUNT;
        end else if (cnt == 3'd7) begin
          dout_r <= {bus.din, shadow};
          fv <= 1'b1;
          cnt <= 3'd0;
        end else begin
          shadow[cnt*W +: W] <= bus.din;
          cnt <= cnt + 3'd1;
        end
      end
    end
  assign bus.dout = dout_r;
  assign bus.frame_valid = fv;
  assign bus.locked = state == LOCKED;
  assign bus.slot = cnt;
  assign bus.sync_err = err;
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: vector table, corner sequences and random stream vs a frame-list model.
module tb_tdm_demux8;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  tdm_demux8_if #(.W(1)) ia ();
  tdm_demux8_if #(.W(1)) ib ();
  tdm_demux8 #(.W(1), .SYNC_EVERY_FRAME(1'b1)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  tdm_demux8 #(.W(1), .SYNC_EVERY_FRAME(1'b0)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  typedef struct {
    logic v, fs, d;
    logic [7:0] dout;
    logic fv, lk, err;
    logic [2:0] slot;
  } vec_t;
  vec_t vt[$];
  int checks = 0, fails = 0;
  int nfv[2], nerr[2];
  bit mlk[2], mfv[2], merr[2];
  int mlen[2];
  logic [7:0] mbuf[2], mdout[2];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mlk[k] = 0; mfv[k] = 0; merr[k] = 0; mlen[k] = 0; mbuf[k] = '0; mdout[k] = '0;
    end
  endtask
  // Model keeps the list of lanes received so far in the current frame.
  task automatic model(int k, bit v, bit fs, bit d);
    mfv[k] = 0;
    merr[k] = 0;
    if (v) begin
      if (!mlk[k]) begin
        if (fs) begin mbuf[k][0] = d; mlen[k] = 1; mlk[k] = 1; end
      end else if (fs) begin
        merr[k] = mlen[k] != 0;
        mbuf[k][0] = d;
        mlen[k] = 1;
      end else if (mlen[k] == 0 && k == 0) begin
        merr[k] = 1;
        mlk[k] = 0;
      end else begin
        mbuf[k][mlen[k]] = d;
        mlen[k]++;
        if (mlen[k] == 8) begin mdout[k] = mbuf[k]; mfv[k] = 1; mlen[k] = 0; end
      end
    end
  endtask
  task automatic cmp();
    chk("a.dout", ia.dout, mdout[0]);
    chk("a.frame_valid", ia.frame_valid, mfv[0]);
    chk("a.locked", ia.locked, mlk[0]);
    chk("a.sync_err", ia.sync_err, merr[0]);
    chk("a.slot", ia.slot, mlen[0]);
    chk("b.dout", ib.dout, mdout[1]);
    chk("b.frame_valid", ib.frame_valid, mfv[1]);
    chk("b.locked", ib.locked, mlk[1]);
    chk("b.sync_err", ib.sync_err, merr[1]);
    chk("b.slot", ib.slot, mlen[1]);
  endtask
  task automatic step(bit v, bit fs, bit d);
    ia.din = d; ia.din_valid = v; ia.frame_sync = fs;
    ib.din = d; ib.din_valid = v; ib.frame_sync = fs;
    @(posedge clk);
    #1;
    model(0, v, fs, d);
    model(1, v, fs, d);
    cmp();
    nfv[0] += int'(ia.frame_valid); nerr[0] += int'(ia.sync_err);
    nfv[1] += int'(ib.frame_valid); nerr[1] += int'(ib.sync_err);
  endtask
  task automatic send_frame(logic [7:0] f, int gap_after = -1);
    for (int i = 0; i < 8; i++) begin
      step(1, i == 0, f[i]);
      if (i == gap_after) begin step(0, 0, 0); step(0, 0, 0); end
    end
  endtask
  task automatic clr();
    nfv = '{0, 0}; nerr = '{0, 0};
  endtask
  function automatic void add(logic v, fs, d, logic [7:0] dout, logic fv, lk, err, logic [2:0] slot);
    vec_t r;
    r.v = v; r.fs = fs; r.d = d; r.dout = dout; r.fv = fv; r.lk = lk; r.err = err; r.slot = slot;
    vt.push_back(r);
  endfunction
  initial begin
    logic [7:0] f;
    bit v, fs;
    f = 8'h4D;
    for (int i = 0; i < 3; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 8'h00, 0, 0, 0, 3'd0);
    for (int i = 0; i < 8; i++) add(1, i == 0, f[i], i == 7 ? 8'h4D : 8'h00, i == 7, 1, 0, 3'((i + 1) % 8));
    add(0, 0, 0, 8'h4D, 0, 1, 0, 3'd0);
    add(1, 0, 1, 8'h4D, 0, 0, 1, 3'd0);
    add(1, 0, 1, 8'h4D, 0, 0, 0, 3'd0);
    for (int i = 0; i < 8; i++) add(1, i == 0, f[i], 8'h4D, i == 7, 1, 0, 3'((i + 1) % 8));
    rst = 1'b1;
    ia.din = 0; ia.din_valid = 0; ia.frame_sync = 0;
    ib.din = 0; ib.din_valid = 0; ib.frame_sync = 0;
    model_reset();
    #2;
    cmp();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].v, vt[i].fs, vt[i].d);
      chk($sformatf("vec%0d.dout", i), ia.dout, vt[i].dout);
      chk($sformatf("vec%0d.frame_valid", i), ia.frame_valid, vt[i].fv);
      chk($sformatf("vec%0d.locked", i), ia.locked, vt[i].lk);
      chk($sformatf("vec%0d.sync_err", i), ia.sync_err, vt[i].err);
      chk($sformatf("vec%0d.slot", i), ia.slot, vt[i].slot);
    end
    clr();
    send_frame(8'h4D, 3);
    chk("gap.first_dout", ia.dout, 8'h4D);
    send_frame(8'hAA);
    chk("gap.second_dout", ia.dout, 8'hAA);
    chk("gap.fv_count", nfv[0], 2);
    chk("gap.err_count", nerr[0], 0);
    clr();
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
    chk("early.dout_held", ia.dout, 8'hAA);
    send_frame(8'h3C);
    chk("early.err_count", nerr[0], 1);
    chk("early.fv_count", nfv[0], 1);
    chk("early.dout", ia.dout, 8'h3C);
    clr();
    f = 8'h96;
    for (int i = 0; i < 8; i++) step(1, 0, f[i]);
    chk("miss.a_err_count", nerr[0], 1);
    chk("miss.a_fv_count", nfv[0], 0);
    chk("miss.a_locked", ia.locked, 0);
    chk("miss.b_fv_count", nfv[1], 1);
    chk("miss.b_err_count", nerr[1], 0);
    chk("miss.b_dout", ib.dout, 8'h96);
    send_frame(8'h5A);
    chk("miss.a_refv_count", nfv[0], 1);
    chk("miss.a_dout", ia.dout, 8'h5A);
    f = 8'hE7;
    for (int i = 0; i < 5; i++) step(1, i == 0, f[i]);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.a_dout", ia.dout, 0);
    chk("rst.a_locked", ia.locked, 0);
    chk("rst.a_slot", ia.slot, 0);
    chk("rst.b_dout", ib.dout, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(8'hC3);
    chk("rst.after_dout", ia.dout, 8'hC3);
    for (int i = 0; i < 1500; i++) begin
      v = $urandom_range(0, 3) != 0;
      fs = ($urandom_range(0, 11) == 0) || (mlen[0] == 0 && $urandom_range(0, 5) != 0);
      step(v, fs, 1'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
